// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Arbiter and sequencer in front of a single-port instruction memory. The
// memory has a 1-cycle registered read and byte-lane write enables. Two
// requesters share it:
//   - the core fetch port (read-only), with a flush input for redirects
//   - the loader/debug port (read/write)
// Ties go round-robin. Each response returns to its owner one cycle after
// the grant. rdata is the memory output, routed to both ports.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_req/f_addr               fetch request (read-only)
//   f_gnt                      fetch accepted this cycle (combinational)
//   f_flush                    drops the fetch response due this cycle and
//                              blocks the fetch grant this cycle
//   f_rvalid/f_rdata           fetch response
//   l_req/l_addr/l_wdata/l_wen loader request; l_wen == 0 means read
//   l_gnt                      loader accepted this cycle (combinational)
//   l_rvalid/l_rdata           loader response (read data or write ack)
//   m_addr/m_wdata/m_wen       memory request side
//   m_rdata                    memory read data, one cycle after the address
// -----------------------------------------------------------------------------
module imem_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  input  logic                  f_flush,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  // loader port
  input  logic                  l_req,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  input  logic [DATA_BYTES-1:0] l_wen,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  // memory side
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [DATA_BYTES-1:0] m_wen,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  // The response tag {resp_v, resp_port} is held as an FSM state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP_F = 2'd1,
    ST_RESP_L = 2'd2
  } state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_e;

  state_e                state_q, state_d;
  port_e                 last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic eff_f;
  logic f_win, l_win;

  assign eff_f = f_req && !f_flush;

  // Arbitration. A flushed fetch does not take part. Grants are gated with
  // rst_n so that both gnt outputs and m_wen drop at once when reset is
  // asserted, without waiting for a clock edge.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    f_win = 1'b0;
    l_win = 1'b0;
    if (rst_n) begin
      if (eff_f && l_req) begin
        // Tie: the port not granted last wins.
        if (last_q == PORT_L) f_win = 1'b1;
        else                  l_win = 1'b1;
      end else if (eff_f) begin
        f_win = 1'b1;
      end else if (l_req) begin
        l_win = 1'b1;
      end
    end
  end

  // State register: response tag, last-granted pointer, held address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_L;  // fetch wins the first tie after reset
      addr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this edge, whatever the order.
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic. A grant always owes a response next cycle; `last`
  // and the held address change only on a grant.
  always_comb begin
    state_d = ST_IDLE;
    last_d  = last_q;
    addr_d  = addr_q;
    if (f_win) begin
      state_d = ST_RESP_F;
      last_d  = PORT_F;
      addr_d  = f_addr;
    end else if (l_win) begin
      state_d = ST_RESP_L;
      last_d  = PORT_L;
      addr_d  = l_addr;
    end
  end

  // Output logic. Without a grant the memory sees the last granted address
  // again, so m_rdata stays stable across idle cycles.
  always_comb begin
    f_gnt    = f_win;
    l_gnt    = l_win;
    m_addr   = addr_q;
    m_wdata  = '0;
    m_wen    = '0;
    if (l_win) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
      m_wen   = l_wen;
    end else if (f_win) begin
      m_addr  = f_addr;
    end
    // A redirect in the response cycle discards the stale fetch data.
    f_rvalid = (state_q == ST_RESP_F) && !f_flush;
    l_rvalid = (state_q == ST_RESP_L);
    f_rdata  = m_rdata;
    l_rdata  = m_rdata;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter. It includes a behavioural memory with a
// 1-cycle registered read and byte-lane writes. A word that has never been
// written reads as {32'hDEAD_BEEF, address}. Inputs change 1 ns after
// posedge. Combinational outputs are checked 1 ns later, and registered
// responses are checked after the following posedge.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

  localparam int AW = 11;
  localparam int DW = 64;
  localparam int DB = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_flush;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DB-1:0] l_wen;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DB-1:0] m_wen;
  logic [DW-1:0] m_rdata;

  int total = 0;
  int bad   = 0;

  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_flush  (f_flush),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_req    (l_req),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_wen    (l_wen),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wen    (m_wen),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  logic [DW-1:0] mem_cur;

  always @(posedge clk) begin
    mem_cur = written[m_addr] ? mem[m_addr] : {32'hDEAD_BEEF, 21'd0, m_addr};
    m_rdata <= mem_cur;
    if (m_wen != '0) begin
      for (int b = 0; b < DB; b++)
        if (m_wen[b]) mem_cur[b*8 +: 8] = m_wdata[b*8 +: 8];
      mem[m_addr]     <= mem_cur;
      written[m_addr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contention table: per cycle, the addresses presented and the expected winner.
  logic [AW-1:0] c_faddr [4] = '{11'd10, 11'd11, 11'd11, 11'd12};
  logic [AW-1:0] c_laddr [4] = '{11'd20, 11'd20, 11'd21, 11'd21};
  logic          c_fwin  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [AW-1:0] c_maddr [4] = '{11'd10, 11'd20, 11'd11, 11'd21};

  initial begin
    rst_n   = 1'b0;
    f_req   = 1'b1;
    f_addr  = 11'd10;
    f_flush = 1'b0;
    l_req   = 1'b1;
    l_addr  = 11'd20;
    l_wdata = '0;
    l_wen   = '0;

    // ---- reset state, with both requests already pending
    #2;
    check("rst_f_gnt",    64'(f_gnt),    64'd0);
    check("rst_l_gnt",    64'(l_gnt),    64'd0);
    check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
    check("rst_l_rvalid", 64'(l_rvalid), 64'd0);
    check("rst_m_wen",    64'(m_wen),    64'd0);
    check("rst_m_addr",   64'(m_addr),   64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---- contention: F,L,F,L with responses one cycle later
    for (int k = 0; k < 4; k++) begin
      f_addr = c_faddr[k];
      l_addr = c_laddr[k];
      #1;
      check($sformatf("cont%0d_f_gnt", k),  64'(f_gnt),  64'(c_fwin[k]));
      check($sformatf("cont%0d_l_gnt", k),  64'(l_gnt),  64'(!c_fwin[k]));
      check($sformatf("cont%0d_m_addr", k), 64'(m_addr), 64'(c_maddr[k]));
      tick();
      check($sformatf("cont%0d_f_rvalid", k), 64'(f_rvalid), 64'(c_fwin[k]));
      check($sformatf("cont%0d_l_rvalid", k), 64'(l_rvalid), 64'(!c_fwin[k]));
      check($sformatf("cont%0d_rdata", k),
            c_fwin[k] ? f_rdata : l_rdata, {32'hDEAD_BEEF, 21'd0, c_maddr[k]});
    end

    // ---- fetch only at addr 5
    l_req  = 1'b0;
    f_addr = 11'd5;
    #1;
    check("fo_f_gnt",  64'(f_gnt),  64'd1);
    check("fo_l_gnt",  64'(l_gnt),  64'd0);
    check("fo_m_addr", 64'(m_addr), 64'd5);
    check("fo_m_wen",  64'(m_wen),  64'd0);
    tick();
    f_req = 1'b0;
    check("fo_f_rvalid", 64'(f_rvalid), 64'd1);
    check("fo_f_rdata",  f_rdata,       64'hDEAD_BEEF_0000_0005);
    check("fo_l_rvalid", 64'(l_rvalid), 64'd0);

    // ---- loader partial write to addr 3
    l_req   = 1'b1;
    l_addr  = 11'd3;
    l_wdata = 64'h1122_3344_5566_7788;
    l_wen   = 8'h0F;
    #1;
    check("wr_l_gnt",   64'(l_gnt),  64'd1);
    check("wr_f_gnt",   64'(f_gnt),  64'd0);
    check("wr_m_wen",   64'(m_wen),  64'h0F);
    check("wr_m_addr",  64'(m_addr), 64'd3);
    check("wr_m_wdata", m_wdata,     64'h1122_3344_5566_7788);
    tick();
    l_wen = '0;
    check("wr_l_rvalid", 64'(l_rvalid), 64'd1);
    check("wr_f_rvalid", 64'(f_rvalid), 64'd0);
    // read back: only the low four byte lanes were written
    #1;
    check("rb_l_gnt", 64'(l_gnt), 64'd1);
    check("rb_m_wen", 64'(m_wen), 64'd0);
    tick();
    l_req = 1'b0;
    check("rb_l_rvalid", 64'(l_rvalid), 64'd1);
    check("rb_l_rdata",  l_rdata,       64'hDEAD_BEEF_5566_7788);

    // ---- flush: fetch addr 7 granted, flush in its response cycle
    f_req  = 1'b1;
    f_addr = 11'd7;
    #1;
    check("fl_f_gnt0", 64'(f_gnt), 64'd1);
    tick();
    f_addr  = 11'd8;
    f_flush = 1'b1;
    l_req   = 1'b1;
    l_addr  = 11'd30;
    #1;
    check("fl_f_rvalid", 64'(f_rvalid), 64'd0);
    check("fl_f_gnt",    64'(f_gnt),    64'd0);
    check("fl_l_gnt",    64'(l_gnt),    64'd1);
    check("fl_m_addr",   64'(m_addr),   64'd30);
    tick();
    f_flush = 1'b0;
    l_req   = 1'b0;
    #1;
    check("fl_l_rvalid", 64'(l_rvalid), 64'd1);
    check("fl_l_rdata",  l_rdata,       {32'hDEAD_BEEF, 32'd30});
    check("fl_f_rvalid1", 64'(f_rvalid), 64'd0);
    check("fl_f_gnt1",   64'(f_gnt),    64'd1);
    tick();
    check("fl_f_rvalid2", 64'(f_rvalid), 64'd1);
    check("fl_f_rdata2",  f_rdata,       {32'hDEAD_BEEF, 32'd8});

    // ---- idle hold after a grant at addr 9
    f_addr = 11'd9;
    #1;
    check("ih_f_gnt", 64'(f_gnt), 64'd1);
    tick();
    f_req = 1'b0;
    check("ih_f_rvalid", 64'(f_rvalid), 64'd1);
    check("ih_f_rdata",  f_rdata,       {32'hDEAD_BEEF, 32'd9});
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ih%0d_m_addr", k),   64'(m_addr),   64'd9);
      check($sformatf("ih%0d_m_wen", k),    64'(m_wen),    64'd0);
      check($sformatf("ih%0d_f_rvalid", k), 64'(f_rvalid), 64'd0);
      check($sformatf("ih%0d_l_rvalid", k), 64'(l_rvalid), 64'd0);
    end

    // ---- reset mid-operation: fetch granted, reset before the response edge
    f_req  = 1'b1;
    f_addr = 11'd12;
    #1;
    check("rm_f_gnt0", 64'(f_gnt), 64'd1);
    l_req = 1'b1;
    l_addr = 11'd40;
    l_wen = 8'hFF;
    #1;
    rst_n = 1'b0;
    #1;
    check("rm_f_rvalid", 64'(f_rvalid), 64'd0);
    check("rm_m_wen",    64'(m_wen),    64'd0);
    check("rm_f_gnt",    64'(f_gnt),    64'd0);
    check("rm_l_gnt",    64'(l_gnt),    64'd0);
    tick();
    check("rm_f_rvalid_edge", 64'(f_rvalid), 64'd0);
    l_wen = '0;
    rst_n = 1'b1;
    #1;
    // Before the reset fetch was granted last; after it fetch must win again.
    check("rm_post_f_gnt", 64'(f_gnt), 64'd1);
    check("rm_post_l_gnt", 64'(l_gnt), 64'd0);
    tick();
    f_req = 1'b0;
    l_req = 1'b0;
    check("rm_post_f_rvalid", 64'(f_rvalid), 64'd1);
    check("rm_post_f_rdata",  f_rdata,       {32'hDEAD_BEEF, 32'd12});
    check("rm_post_l_rvalid", 64'(l_rvalid), 64'd0);
    tick();
    check("rm_end_f_rvalid", 64'(f_rvalid), 64'd0);
    check("rm_end_l_rvalid", 64'(l_rvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
